// File: rtl/aes_enc_seq_ctrl.sv
// aes_enc_seq_ctrl: handshake-driven sequencer for the multi-cycle AES encryption engine
package aes_enc_seq_pkg;
  typedef enum logic [1:0] {
    KEXP_NOOP    = 2'd0,
    KEXP_ENC_128 = 2'd1,
    KEXP_ENC_192 = 2'd2,
    KEXP_ENC_256 = 2'd3
  } kexp_mode_e;
endpackage

module aes_enc_seq_ctrl
  import aes_enc_seq_pkg::*;
#(
  parameter int BLK_W = 128,
  parameter int KEY_W = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [KEY_W-1:0] in_key,
  input  logic [BLK_W-1:0] in_data,
  output kexp_mode_e       kexp_mode_o,
  output logic [KEY_W-1:0] kexp_key_o,
  input  logic [BLK_W-1:0] kexp_rk_i,
  output logic [BLK_W-1:0] rnd_state_o,
  output logic             rnd_last_o,
  input  logic [BLK_W-1:0] rnd_out_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy,
  output logic             err_o
);
  typedef enum logic [1:0] {IDLE, KLOAD, ROUNDS, DONE} state_e;

  state_e           state_q, state_d;
  kexp_mode_e       mode_q, acc_mode;
  logic [3:0]       k_q, nr_q, acc_nr;
  logic [KEY_W-1:0] key_q, acc_key;
  logic [BLK_W-1:0] data_q, st_q;
  logic             err_q, req_ok, req_bad, last_k;

  assign req_ok  = state_q == IDLE && in_valid && in_mode != 2'b11;
  assign req_bad = state_q == IDLE && in_valid && in_mode == 2'b11;
  assign last_k  = k_q == nr_q;

  // Decode the requested mode: key-expansion command, round count and zeroed unused key words
  always_comb begin
    acc_mode = in_mode == 2'b00 ? KEXP_ENC_128 : in_mode == 2'b01 ? KEXP_ENC_192 : KEXP_ENC_256;
    acc_nr   = in_mode == 2'b00 ? 4'd10 : in_mode == 2'b01 ? 4'd12 : 4'd14;
    acc_key  = in_mode == 2'b00 ? {in_key[255:128], 128'd0} :
               in_mode == 2'b01 ? {in_key[255:64], 64'd0} : in_key;
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  // Next state: once KLOAD is entered the sequence runs to DONE without stalling
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req_ok ? KLOAD : IDLE;
      KLOAD:   state_d = ROUNDS;
      ROUNDS:  state_d = last_k ? DONE : ROUNDS;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, round counter, round-state register with AddRoundKey, error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= KEXP_NOOP;
      nr_q   <= 4'd0;
      key_q  <= '0;
      data_q <= '0;
      st_q   <= '0;
      k_q    <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      err_q <= req_bad;
      k_q   <= state_q == ROUNDS ? k_q + 4'd1 : 4'd0;
      if (req_ok) begin
        mode_q <= acc_mode;
        nr_q   <= acc_nr;
        key_q  <= acc_key;
        data_q <= in_data;
      end
      if (state_q == ROUNDS) st_q <= (k_q == 4'd0 ? data_q : rnd_out_i) ^ kexp_rk_i;
    end

  // Key expansion steps in KLOAD and every round but the last, so it is back at load on the final key
  assign kexp_mode_o = (state_q == KLOAD || (state_q == ROUNDS && !last_k)) ? mode_q : KEXP_NOOP;
  assign kexp_key_o  = key_q;
  assign rnd_state_o = st_q;
  assign rnd_last_o  = state_q == ROUNDS && last_k;
  assign out_data    = st_q;
  assign out_valid   = state_q == DONE;
  assign in_ready    = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign err_o       = err_q;
endmodule

// File: tb/tb_aes_enc_seq_ctrl.sv
// tb_aes_enc_seq_ctrl: scoreboard bench with behavioural AES key expansion, round datapath and reference cipher
module tb_aes_enc_seq_ctrl;
  import aes_enc_seq_pkg::*;

  logic         clk = 0, rst_n = 0, in_valid = 0;
  logic         in_ready, rnd_last_o, out_valid, busy, err_o, out_ready;
  logic [1:0]   in_mode = 0;
  logic [255:0] in_key = 0, kexp_key_o;
  logic [127:0] in_data = 0, kexp_rk_i, rnd_state_o, rnd_out_i, out_data;
  kexp_mode_e   kexp_mode_o;
  logic         rnd_bp = 0, rnd_r = 1, hold_r = 1;
  int           cyc = 0, checks = 0, errors = 0;

  typedef struct {logic [127:0] ct; logic [255:0] key; int nk; int acc;} exp_t;
  exp_t sb[$];

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'hfedcba9876543210a5a5a5a55a5a5a5a};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hcafef00ddeadbeef};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_enc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_key(in_key), .in_data(in_data), .kexp_mode_o(kexp_mode_o), .kexp_key_o(kexp_key_o),
    .kexp_rk_i(kexp_rk_i), .rnd_state_o(rnd_state_o), .rnd_last_o(rnd_last_o),
    .rnd_out_i(rnd_out_i), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = xt(x);
    end
    return r;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p = x, v = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gm(p, p);
      v = gm(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  // SubBytes, ShiftRows and (unless last) MixColumns; AddRoundKey belongs to the DUT
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0]   b[16], t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    if (!last)
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
        t[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
      end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  // FIPS-197 key schedule; returns round key r for an nk-word key
  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w[64];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          rr = r > 14 ? 14 : r;
    for (int i = 0; i < 4*rr+4; i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [127:0] s = pt ^ round_key(key, nk, 0);
    for (int r = 1; r <= nk + 6; r++) s = aes_round(s, r == nk + 6) ^ round_key(key, nk, r);
    return s;
  endfunction

  function automatic logic [255:0] mask_key(input logic [255:0] k, input int nk);
    for (int i = nk; i < 8; i++) k[255-32*i -: 32] = '0;
    return k;
  endfunction

  function automatic kexp_mode_e mode_of(input int nk);
    return nk == 4 ? KEXP_ENC_128 : nk == 6 ? KEXP_ENC_192 : KEXP_ENC_256;
  endfunction

  function automatic int nk_of(input kexp_mode_e m);
    return m == KEXP_ENC_128 ? 4 : m == KEXP_ENC_192 ? 6 : 8;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Key-expansion environment: loads on the first non-NOOP edge, then steps one round key per command
  logic         kx_on = 0;
  int           kx_idx = 0, kx_nk = 4;
  logic [255:0] kx_key = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      kx_on  <= 0;
      kx_idx <= 0;
    end else if (kexp_mode_o == KEXP_NOOP) kx_on <= 0;
    else if (!kx_on) begin
      kx_on  <= 1;
      kx_idx <= 0;
      kx_key <= kexp_key_o;
      kx_nk  <= nk_of(kexp_mode_o);
    end else kx_idx <= kx_idx + 1;

  assign kexp_rk_i = round_key(kx_key, kx_nk, kx_idx);
  assign rnd_out_i = aes_round(rnd_state_o, rnd_last_o);
  assign out_ready = rnd_bp ? rnd_r : hold_r;

  initial forever begin
    @(posedge clk);
    #1 rnd_r = $urandom_range(0, 3) != 0;
  end

  // Monitor: per-block timing, key-expansion command checks and ciphertext scoreboard
  int           kcnt = 0, lcnt = 0;
  logic         vseen = 0;
  logic [127:0] hold_v = '0;
  exp_t         e;
  always @(negedge clk) begin
    if (!rst_n) begin
      kcnt = 0; lcnt = 0; vseen = 0;
    end else begin
      if (kexp_mode_o != KEXP_NOOP) begin
        if (sb.size() == 0) chk("kexp_unexpected", kexp_mode_o, KEXP_NOOP);
        else begin
          if (kcnt == 0) chk("kexp_key", kexp_key_o, mask_key(sb[0].key, sb[0].nk));
          chk("kexp_mode", kexp_mode_o, mode_of(sb[0].nk));
        end
        kcnt++;
      end
      if (rnd_last_o) begin
        lcnt++;
        if (sb.size() == 0) chk("last_unexpected", rnd_last_o, 0);
        else chk("last_cycle", cyc - sb[0].acc, sb[0].nk + 8);
      end
      if (out_valid) begin
        if (sb.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          if (!vseen) begin
            vseen = 1;
            hold_v = out_data;
            chk("latency", cyc - sb[0].acc, sb[0].nk + 9);
          end else chk("out_hold", out_data, hold_v);
          chk("in_ready_done", in_ready, 0);
          if (out_ready) begin
            e = sb.pop_front();
            chk("ciphertext", out_data, e.ct);
            chk("kexp_cycles", kcnt, e.nk + 7);
            chk("last_count", lcnt, 1);
            kcnt = 0; lcnt = 0; vseen = 0;
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [1:0] m, input logic [255:0] k, input logic [127:0] d, input logic [127:0] ct);
    int n = 0;
    in_valid = 1; in_mode = m; in_key = k; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else sb.push_back('{ct: ct, key: k, nk: 4 + 2*int'(m), acc: cyc});
    @(posedge clk);
    #1 in_valid = 0;
    in_mode = 2'($urandom); in_key = rnd256(); in_data = rnd256()[127:0];
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_kexp_mode"}, kexp_mode_o, KEXP_NOOP);
    chk({tag, "_kexp_key"}, kexp_key_o, 0);
    chk({tag, "_rnd_state"}, rnd_state_o, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_rnd_last"}, rnd_last_o, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int n;
    logic [1:0]   m;
    logic [255:0] k;
    logic [127:0] d;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1;
    send(2'b00, K128, PT, CT128);
    send(2'b01, K192, PT, CT192);
    send(2'b10, K256, PT, CT256);
    wait_idle();
    hold_r = 0;
    send(2'b00, K128, PT, CT128);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", out_valid, 1);
    repeat (20) @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_data", out_data, CT128);
    @(posedge clk);
    #1 hold_r = 1;
    send(2'b00, K128, PT, CT128);
    send(2'b10, K256, PT, CT256);
    send(2'b01, K192, PT, CT192);
    wait_idle();
    in_valid = 1; in_mode = 2'b11; in_key = rnd256(); in_data = PT;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    chk("err_pulse", err_o, 1);
    chk("err_busy", busy, 0);
    chk("err_kexp", kexp_mode_o, KEXP_NOOP);
    @(negedge clk);
    chk("err_clear", err_o, 0);
    chk("err_busy2", busy, 0);
    @(posedge clk);
    #1 k = rnd256();
    send(2'b10, k, PT, aes_enc(k, 8, PT));
    wait_idle();
    send(2'b00, K128, PT, CT128);
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_round", kx_idx, 5);
    rst_n = 0;
    #1 reset_vals("midrst");
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    send(2'b00, K128, PT, CT128);
    rnd_bp = 1;
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom_range(0, 2));
      k = rnd256();
      d = rnd256()[127:0];
      send(m, k, d, aes_enc(k, 4 + 2*int'(m), d));
    end
    wait_idle();
    rnd_bp = 0;
    repeat (3) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
